// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and iteration constants for the mul/div unit
package mdu_pkg;
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;
  localparam int WORD_ITERS = 32;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: restoring divider on magnitudes, one quotient bit per step
module mdu_div_core #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt
);
  logic [XLEN-1:0] quo, rem, dvs;
  logic [XLEN:0] trial;
  logic ok;
  assign trial = {rem, quo[XLEN-1]} - {1'b0, dvs};
  assign ok = !trial[XLEN];
  assign rem_nxt = ok ? trial[XLEN-1:0] : {rem[XLEN-2:0], quo[XLEN-1]};
  assign quo_nxt = {quo[XLEN-2:0], ok};
  // word dividends are parked in the top half so 32 steps consume exactly their bits
  always_ff @(posedge clk) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (load) begin
      quo <= word ? {dividend[31:0], {(XLEN-32){1'b0}}} : dividend;
      rem <= '0;
      dvs <= divisor;
    end else if (step) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
  end
endmodule

// File: rtl/ex_mul_div_unit.sv
// ex_mul_div_unit: iterative RV64M multiply/divide for the EX stage with stall/flush handshake
module ex_mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush_i,
  input  logic            ready_i,
  output logic            stall_req_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0] op_q;
  logic word_q, neg_q, rneg_q;
  logic [XLEN-1:0] mcand, res_q, a_ext, b_ext, a_mag, b_mag, min_val, spec_res;
  logic [XLEN-1:0] quo_nxt, rem_nxt, dq, dr, mres, calc_res;
  logic [2*XLEN-1:0] prod, prod_nxt, mfull;
  logic [XLEN:0] sum;
  logic a_sgn, b_sgn, a_neg, b_neg, div_zero, ovf, go, last, kill;

  function automatic logic [XLEN-1:0] wx(input logic w, input logic s, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){s & v[31]}}, v[31:0]} : v;
  endfunction

  assign kill = flush_i | rst;
  assign go = state == S_IDLE && start_i && !kill;
  assign last = state == S_CALC && cnt == CNT_W'(1);
  assign a_sgn = op_i == OP_MULH || op_i == OP_MULHSU || op_i == OP_DIV || op_i == OP_REM;
  assign b_sgn = op_i == OP_MULH || op_i == OP_DIV || op_i == OP_REM;
  assign a_ext = wx(word_i, a_sgn, src1_i);
  assign b_ext = wx(word_i, b_sgn, src2_i);
  assign a_neg = a_sgn & a_ext[XLEN-1];
  assign b_neg = b_sgn & b_ext[XLEN-1];
  assign a_mag = a_neg ? -a_ext : a_ext;
  assign b_mag = b_neg ? -b_ext : b_ext;
  assign min_val = word_i ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = op_i[2] && b_ext == '0;
  assign ovf = op_i[2] && !op_i[0] && a_ext == min_val && &b_ext;
  assign spec_res = wx(word_i, 1'b1, op_i[1] ? (div_zero ? a_ext : '0) : (div_zero ? '1 : a_ext));

  // shift-add: multiplier sits in the low half and is consumed as the sum shifts in
  assign sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_nxt = {sum, prod[XLEN-1:1]};
  assign mfull = neg_q ? -prod_nxt : prod_nxt;
  assign mres = op_q != OP_MUL ? mfull[2*XLEN-1:XLEN] :
                word_q ? wx(1'b1, 1'b1, {{(XLEN-32){1'b0}}, prod_nxt[XLEN-1 -: 32]}) : prod_nxt[XLEN-1:0];
  assign dq = neg_q ? -quo_nxt : quo_nxt;
  assign dr = rneg_q ? -rem_nxt : rem_nxt;
  assign calc_res = op_q[2] ? wx(word_q, 1'b1, op_q[1] ? dr : dq) : mres;

  mdu_div_core #(.XLEN(XLEN)) u_div (
    .clk(clk),
    .rst(rst),
    .load(go),
    .step(state == S_CALC),
    .word(word_i),
    .dividend(a_mag),
    .divisor(b_mag),
    .quo_nxt(quo_nxt),
    .rem_nxt(rem_nxt)
  );

  always_comb begin
    state_nxt = kill ? S_IDLE :
                state == S_IDLE ? (go ? (div_zero || ovf ? S_DONE : S_CALC) : S_IDLE) :
                state == S_CALC ? (last ? S_DONE : S_CALC) :
                ready_i ? S_IDLE : S_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      op_q <= '0;
      word_q <= 1'b0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      prod <= '0;
      mcand <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      if (go) begin
        op_q <= op_i;
        word_q <= word_i;
        neg_q <= a_neg ^ b_neg;
        rneg_q <= a_neg;
        cnt <= word_i ? CNT_W'(WORD_ITERS) : CNT_W'(XLEN);
        prod <= {{XLEN{1'b0}}, b_mag};
        mcand <= a_mag;
        if (div_zero || ovf) res_q <= spec_res;
      end else if (state == S_CALC && !flush_i) begin
        cnt <= cnt - CNT_W'(1);
        prod <= prod_nxt;
        if (last) res_q <= calc_res;
      end
    end
  end

  assign stall_req_o = go || (state == S_CALC && !kill);
  assign result_valid_o = state == S_DONE && !kill;
  assign result_o = res_q;
endmodule

// File: tb/tb_ex_mul_div_unit.sv
// tb_ex_mul_div_unit: directed and random checks of the mul/div unit against an arithmetic model
module tb_ex_mul_div_unit;
  logic clk = 1'b0;
  logic rst, start_i, word_i, flush_i, ready_i, stall_req_o, result_valid_o;
  logic [2:0] op_i;
  logic [63:0] src1_i, src2_i, result_o;
  int n_cmp = 0;
  int n_bad = 0;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  always #5 clk = ~clk;

  ex_mul_div_unit dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .op_i(op_i),
    .word_i(word_i),
    .src1_i(src1_i),
    .src2_i(src2_i),
    .flush_i(flush_i),
    .ready_i(ready_i),
    .stall_req_o(stall_req_o),
    .result_o(result_o),
    .result_valid_o(result_valid_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0] x, y, r;
    logic signed [63:0] sx, sy;
    logic sg;
    if (!op[2]) begin
      p = {{64{a[63] & (op == 3'd1 || op == 3'd2)}}, a} * {{64{b[63] & (op == 3'd1)}}, b};
      if (op != 3'd0) return p[127:64];
      return w ? {{32{p[31]}}, p[31:0]} : p[63:0];
    end
    sg = !op[0];
    x = w ? {{32{sg & a[31]}}, a[31:0]} : a;
    y = w ? {{32{sg & b[31]}}, b[31:0]} : b;
    sx = x;
    sy = y;
    if (y == 64'd0) r = op[1] ? x : '1;
    else if (sg && x == MIN64 && &y) r = op[1] ? 64'd0 : x;
    else if (sg) begin
      if (op[1]) r = sx % sy;
      else r = sx / sy;
    end else r = op[1] ? x % y : x / y;
    return w ? {{32{r[31]}}, r[31:0]} : r;
  endfunction

  function automatic int exp_stalls(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic zero, ov;
    if (!op[2]) return w ? 33 : 65;
    zero = w ? b[31:0] == 32'd0 : b == 64'd0;
    ov = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && &b[31:0]) : (a == MIN64 && &b));
    return (zero || ov) ? 1 : (w ? 33 : 65);
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int hold);
    int st;
    bit seen;
    logic [63:0] r;
    st = 0;
    seen = 0;
    start_i = 1;
    op_i = op;
    word_i = w;
    src1_i = a;
    src2_i = b;
    ready_i = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      #1;
      if (result_valid_o) seen = 1;
      else begin
        if (stall_req_o) st++;
        @(posedge clk);
        #1;
      end
    end
    chk({tag, "/valid"}, 64'(seen), 64'd1);
    chk({tag, "/stalls"}, 64'(st), 64'(exp_stalls(op, w, a, b)));
    chk({tag, "/result"}, result_o, exp);
    chk({tag, "/stall_done"}, 64'(stall_req_o), 64'd0);
    r = result_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #2;
      chk({tag, "/hold_result"}, result_o, r);
      chk({tag, "/hold_valid"}, {62'd0, stall_req_o, result_valid_o}, 64'd1);
    end
    ready_i = 1;
    @(posedge clk);
    #1;
    start_i = 0;
    ready_i = 0;
    #1;
    chk({tag, "/idle"}, {62'd0, stall_req_o, result_valid_o}, 64'd0);
  endtask

  task automatic abort(input bit use_rst);
    int nv;
    nv = 0;
    start_i = 1;
    op_i = 3'd0;
    word_i = 0;
    src1_i = 64'd7;
    src2_i = 64'd6;
    ready_i = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort/calc_stall", 64'(stall_req_o), 64'd1);
    if (use_rst) rst = 1;
    else flush_i = 1;
    start_i = 0;
    #1;
    chk("abort/stall_drop", {62'd0, stall_req_o, result_valid_o}, 64'd0);
    @(posedge clk);
    #1;
    rst = 0;
    flush_i = 0;
    #1;
    chk("abort/after", {62'd0, stall_req_o, result_valid_o}, 64'd0);
    if (use_rst) chk("abort/rst_result", result_o, 64'd0);
    repeat (70) begin
      @(posedge clk);
      #1;
      if (result_valid_o || stall_req_o) nv++;
    end
    chk("abort/quiet", 64'(nv), 64'd0);
  endtask

  initial begin
    logic [2:0] op;
    logic w;
    logic [63:0] a, b;
    rst = 1;
    start_i = 0;
    flush_i = 0;
    ready_i = 0;
    op_i = 0;
    word_i = 0;
    src1_i = 0;
    src2_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/result", result_o, 64'd0);
    chk("reset/flags", {62'd0, stall_req_o, result_valid_o}, 64'd0);
    rst = 0;
    #1;
    run_op("mul7x6", 3'd0, 0, 64'd7, 64'd6, 64'd42, 0);
    run_op("mulhu", 3'd3, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op("mulh", 3'd1, 0, '1, '1, 64'd0, 0);
    run_op("divw", 3'd4, 1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("remw", 3'd6, 1, -64'sd7, 64'd2, '1, 0);
    run_op("div0", 3'd4, 0, 64'd5, 64'd0, '1, 0);
    run_op("rem0", 3'd6, 0, 64'd5, 64'd0, 64'd5, 0);
    run_op("divovf", 3'd4, 0, MIN64, '1, MIN64, 0);
    run_op("removf", 3'd6, 0, MIN64, '1, 64'd0, 0);
    run_op("divu_hold", 3'd5, 0, 64'd100, 64'd3, 64'd33, 4);
    abort(0);
    run_op("mul3x3_flush", 3'd0, 0, 64'd3, 64'd3, 64'd9, 0);
    abort(1);
    run_op("mul3x3_rst", 3'd0, 0, 64'd3, 64'd3, 64'd9, 0);
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      w = (op == 3'd1 || op == 3'd2 || op == 3'd3) ? 1'b0 : 1'($urandom_range(0, 1));
      a = $urandom_range(0, 4) == 0 ? (w ? 64'h8000_0000 : MIN64) : {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = 64'($urandom_range(1, 1000));
        1: b = 64'd0;
        2: b = '1;
        default: b = {$urandom, $urandom};
      endcase
      run_op($sformatf("rand%0d_op%0d_w%0d", i, op, w), op, w, a, b, ref_res(op, w, a, b), $urandom_range(0, 2));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
